// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder controller: one full-adder step (two half-adder stages plus OR) per cycle.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUBTRACT_EN.
module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       fa_s;
    logic             sub_s;

`ifdef SERIAL_ADD_SUBTRACT_EN
    assign sub_s = sub;
`else
    logic unused_sub_s;
    assign unused_sub_s = sub;
    assign sub_s        = 1'b0;
`endif

    // Full-adder cell from two half-adder stages; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        logic s1, c1, c2;
        s1 = a ^ b;
        c1 = a & b;
        c2 = s1 & cin;
        return {c1 | c2, s1 ^ cin};
    endfunction

    // Next-state logic: accept in IDLE, one bit per enabled cycle in RUN.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        fa_s    = 2'b00;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_d     = op_a;
                        b_d     = sub_s ? ~op_b : op_b;
                        carry_d = sub_s;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    fa_s    = full_add(a_q[0], b_q[0], carry_q);
                    carry_d = fa_s[1];
                    sum_d   = {fa_s[0], sum_q[WIDTH-1:1]};
                    a_d     = {1'b0, a_q[WIDTH-1:1]};
                    b_d     = {1'b0, b_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_d == CNT_LAST) begin
                        cout_d  = fa_s[1];
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end else begin
            // Stall: everything holds, but a pending done pulse is dropped.
            done_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
